// File: rtl/dsm_dec_pkg.sv
// Shared types and default sizing for the delta-sigma sinc^2 decimator.
// Pure declarations; no logic, no latency, no handshake.
package dsm_dec_pkg;

    typedef enum logic [1:0] {
        WARM0 = 2'd0,
        WARM1 = 2'd1,
        RUN   = 2'd2
    } dsm_state_t;

    localparam int DSM_DECIM_LOG2_DEF = 8;
    localparam int DSM_OUT_W_DEF      = 16;
    localparam int DSM_ACC_W_DEF      = 2 * DSM_DECIM_LOG2_DEF + 1;

    // Two integrator stages of a 1-bit stream with ratio R need 2*log2(R)+1 bits
    function automatic int acc_width(input int decim_log2);
        return 2 * decim_log2 + 1;
    endfunction

endpackage

// File: rtl/dsm_dec_comb.sv
// Comb stage: dout = din minus din captured at the previous enabled edge, modulo 2^W.
// Latency 0 (combinational difference); history updates only when en; no backpressure.
module dsm_dec_comb
    import dsm_dec_pkg::*;
#(
    parameter int W = DSM_ACC_W_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    logic [W-1:0] prev;

    always_ff @(posedge clk) begin
        if (!reset) begin
            prev <= '0;
        end else if (en) begin
            prev <= din;
        end
    end

    assign dout = din - prev;

endmodule

// File: rtl/dsm_decimator.sv
// Sinc^2 (CIC) decimator for a 1-bit delta-sigma stream, ratio 2^DECIM_LOG2; DSM_DEC_SAT_EN clamps overflow.
// Latency: result registered 1 cycle after the R-th sample of a window; first result after 3 windows.
// Backpressure: valid/ready; an unaccepted result is overwritten and flags sticky overrun.
module dsm_decimator
    import dsm_dec_pkg::*;
#(
    parameter int DECIM_LOG2 = DSM_DECIM_LOG2_DEF,
    parameter int OUT_W      = DSM_OUT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             bit_in,
    input  logic             bit_valid,
    output logic [OUT_W-1:0] data_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overrun
);

    localparam int W = acc_width(DECIM_LOG2);

    logic [W-1:0]          i1;
    logic [W-1:0]          i2;
    logic [W-1:0]          i1_nxt;
    logic [W-1:0]          i2_nxt;
    logic [W-1:0]          c1;
    logic [W-1:0]          y;
    logic [DECIM_LOG2-1:0] cnt;
    logic                  dump;
    logic                  result_vld;
    logic [OUT_W-1:0]      y_out;
    dsm_state_t            state;

    // Integrators chain on the updated values so the dump sees the R-th sample
    assign i1_nxt = i1 + W'(bit_in);
    assign i2_nxt = i2 + i1_nxt;
    assign dump   = bit_valid & (&cnt);

    always_ff @(posedge clk) begin
        if (!reset) begin
            i1  <= '0;
            i2  <= '0;
            cnt <= '0;
        end else if (bit_valid) begin
            i1  <= i1_nxt;
            i2  <= i2_nxt;
            cnt <= cnt + DECIM_LOG2'(1);
        end
    end

    dsm_dec_comb #(.W(W)) u_comb1 (
        .clk   (clk),
        .reset (reset),
        .en    (dump),
        .din   (i2_nxt),
        .dout  (c1)
    );

    dsm_dec_comb #(.W(W)) u_comb2 (
        .clk   (clk),
        .reset (reset),
        .en    (dump),
        .din   (c1),
        .dout  (y)
    );

`ifdef DSM_DEC_SAT_EN
    assign y_out = (|(y >> OUT_W)) ? '1 : OUT_W'(y);
`else
    assign y_out = OUT_W'(y);
`endif

    assign result_vld = dump && (state == RUN);

    // The first two dumps only prime the comb history
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= WARM0;
            data_out  <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (dump) begin
                case (state)
                    WARM0:   state <= WARM1;
                    WARM1:   state <= RUN;
                    default: state <= RUN;
                endcase
            end
            if (result_vld) begin
                data_out  <= y_out;
                out_valid <= 1'b1;
                if (out_valid && !out_ready) begin
                    overrun <= 1'b1;
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dsm_decimator.sv
// Randomized and directed stimulus against a triangular-FIR reference of the sinc^2 decimator.
module tb_dsm_decimator;

    localparam int DL = 8;
    localparam int R  = 1 << DL;
    localparam int OW = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          bit_in = 1'b0;
    logic          bit_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [OW-1:0] data_out;
    logic          out_valid;
    logic          overrun;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dsm_decimator #(.DECIM_LOG2(DL), .OUT_W(OW)) dut (
        .clk       (clk),
        .reset     (reset),
        .bit_in    (bit_in),
        .bit_valid (bit_valid),
        .data_out  (data_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overrun   (overrun)
    );

    // Reference: accepted-sample history, window position, dumps since reset, output register
    int q[$];
    int wcnt;
    int ndump;
    bit m_vld;
    bit m_ovr;
    int m_dat;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // sinc^2 of ratio R is a 2R-1 tap triangular FIR, weights 1..R..1, newest sample weight 1
    function automatic int expected_y();
        longint s = 0;
        int     n = q.size();
        for (int j = 0; j < 2 * R - 1 && j < n; j++) begin
            s += longint'((j < R) ? (j + 1) : (2 * R - 1 - j)) * longint'(q[n - 1 - j]);
        end
`ifdef DSM_DEC_SAT_EN
        if (s >= (longint'(1) << OW)) s = (longint'(1) << OW) - 1;
`else
        s = s % (longint'(1) << OW);
`endif
        return int'(s);
    endfunction

    task automatic step(input bit rst_n, input bit bv, input bit b, input bit rdy);
        bit res;
        int y;
        res = 1'b0;
        y   = 0;
        reset     = rst_n;
        bit_valid = bv;
        bit_in    = b;
        out_ready = rdy;
        @(posedge clk);
        if (!rst_n) begin
            q.delete();
            wcnt  = 0;
            ndump = 0;
            m_vld = 1'b0;
            m_ovr = 1'b0;
            m_dat = 0;
        end else begin
            if (bv) begin
                q.push_back(int'(b));
                if (q.size() > 2 * R) void'(q.pop_front());
                wcnt++;
                if (wcnt == R) begin
                    wcnt = 0;
                    ndump++;
                    if (ndump >= 3) begin
                        res = 1'b1;
                        y   = expected_y();
                    end
                end
            end
            if (res) begin
                if (m_vld && !rdy) m_ovr = 1'b1;
                m_vld = 1'b1;
                m_dat = y;
            end else if (m_vld && rdy) begin
                m_vld = 1'b0;
            end
        end
        #1;
        chk("out_valid", 32'(out_valid), 32'(m_vld));
        chk("data_out", 32'(data_out), 32'(m_dat));
        chk("overrun", 32'(overrun), 32'(m_ovr));
    endtask

    initial begin
        int first;
        int nres;
        int acc;
        bit phase;
        logic [31:0] ones_exp;

`ifdef DSM_DEC_SAT_EN
        ones_exp = 32'hFFFF;
`else
        ones_exp = 32'h0000;
`endif

        // Reset state
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        chk("rst_data", 32'(data_out), 32'h0);
        chk("rst_vld", 32'(out_valid), 32'h0);
        chk("rst_ovr", 32'(overrun), 32'h0);

        // All zeros: first result exactly after three windows
        first = -1;
        for (int i = 0; i < 4 * R; i++) begin
            step(1'b1, 1'b1, 1'b0, 1'b1);
            if (out_valid && first < 0) begin
                first = i + 1;
                chk("zero_data", 32'(data_out), 32'h0);
            end
        end
        chk("zero_first", 32'(first), 32'(3 * R));

        // All ones: full-scale gain R^2
        step(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4 * R; i++) begin
            step(1'b1, 1'b1, 1'b1, 1'b1);
            if (out_valid) chk("ones_data", 32'(data_out), ones_exp);
        end

        // Alternating 1,0: half scale, one result per window
        step(1'b0, 1'b0, 1'b0, 1'b0);
        nres  = 0;
        phase = 1'b1;
        for (int i = 0; i < 6 * R; i++) begin
            step(1'b1, 1'b1, phase, 1'b1);
            phase = ~phase;
            if (out_valid) begin
                nres++;
                chk("alt_data", 32'(data_out), 32'h8000);
            end
        end
        chk("alt_count", 32'(nres), 32'd4);

        // Random density, gapped strobe, random ready
        step(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10 * R; i++) begin
            step(1'b1, ($urandom_range(0, 3) != 0), ($urandom_range(0, 99) < 37),
                 $urandom_range(0, 1) == 1);
        end

        // Overrun: ready held low across two result dumps
        step(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3 * R; i++) step(1'b1, 1'b1, $urandom_range(0, 1) == 1, 1'b1);
        for (int i = 0; i < 2 * R; i++) step(1'b1, 1'b1, $urandom_range(0, 1) == 1, 1'b0);
        chk("ovr_set", 32'(overrun), 32'h1);
        chk("ovr_vld", 32'(out_valid), 32'h1);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, 1'b1);
        chk("ovr_sticky", 32'(overrun), 32'h1);

        // Acceptance coinciding with a new result must not flag overrun
        step(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5 * R; i++) begin
            step(1'b1, 1'b1, $urandom_range(0, 1) == 1, (wcnt == R - 1));
        end
        chk("coin_ovr", 32'(overrun), 32'h0);
        chk("coin_vld", 32'(out_valid), 32'h1);

        // First-order modulator at alpha=0x4000 (quarter density)
        step(1'b0, 1'b0, 1'b0, 1'b0);
        acc = 0;
        for (int i = 0; i < 5 * R; i++) begin
            acc = acc + 32'h4000;
            step(1'b1, 1'b1, acc >= 32'h10000, 1'b1);
            acc = acc & 32'hFFFF;
            if (out_valid) begin
                chk("dsm_range", 32'((data_out >= 16'h3F00) && (data_out <= 16'h4100)), 32'h1);
            end
        end

        // Reset 100 samples into a RUN window with a pending result
        for (int i = 0; i < 100; i++) begin
            acc = acc + 32'h4000;
            step(1'b1, 1'b1, acc >= 32'h10000, 1'b0);
            acc = acc & 32'hFFFF;
        end
        step(1'b0, 1'b1, 1'b1, 1'b0);
        chk("mid_data", 32'(data_out), 32'h0);
        chk("mid_vld", 32'(out_valid), 32'h0);
        chk("mid_ovr", 32'(overrun), 32'h0);
        first = -1;
        for (int i = 0; i < 3 * R + 4; i++) begin
            step(1'b1, 1'b1, 1'b1, 1'b1);
            if (out_valid && first < 0) first = i + 1;
        end
        chk("mid_first", 32'(first), 32'(3 * R));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dsm_decimator.md
DSM_DECIMATOR -- requirements
Module: dsm_decimator

Interface
REQ-001 SHALL have parameter DECIM_LOG2, default 8, log2 of decimation ratio R (R=256); legal range 4..8.
REQ-002 SHALL have parameter OUT_W, default 16, output word width; fixed at 2*DECIM_LOG2 when DECIM_LOG2=8.
REQ-003 SHALL have port clk  input  1  single clock, all logic rising-edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have port bit_in  input  1  delta-sigma bitstream sample (the MSB stream of dsm_3).
REQ-006 SHALL have port bit_valid  input  1  sample strobe; bit_in consumed on clk edges where high.
REQ-007 SHALL have port data_out  output  OUT_W  decimated unsigned value.
REQ-008 SHALL have port out_valid  output  1  data_out holds an unconsumed result.
REQ-009 SHALL have port out_ready  input  1  consumer accepts data_out when high with out_valid.
REQ-010 SHALL have port overrun  output  1  sticky flag: a result was overwritten before acceptance.

Function
REQ-011 SHALL implement a 2nd-order sinc (CIC) decimator: two integrators at sample rate, two combs at rate 1/R.
REQ-012 Integrators SHALL be 2*DECIM_LOG2+1 bits wide, wrap modulo 2^width; I1 += bit_in, I2 += I1, only when bit_valid=1.
REQ-013 Sample counter SHALL count accepted samples 0..R-1 and wrap; the dump event occurs on the accepted sample taking it from R-1 to 0.
REQ-014 At dump: C1 = I2 - I2_prev, y = C1 - C1_prev (modular, same width); I2_prev and C1_prev updated.
REQ-015 Gain SHALL be R^2: all-ones input gives y=R^2, all-zeros gives 0, 50% density gives R^2/2.
REQ-016 Control FSM SHALL have states WARM0, WARM1, RUN; reset enters WARM0; each dump advances WARM0->WARM1->RUN; RUN holds.
REQ-017 Dumps in WARM0/WARM1 SHALL update comb history but SHALL NOT produce a result.
REQ-018 A dump in RUN SHALL load data_out and set out_valid on the clk edge following the R-th sample (latency 1 cycle).
REQ-019 out_valid SHALL stay high and data_out stable until a cycle with out_valid=1 and out_ready=1; then out_valid clears.
REQ-020 New result with out_valid=1 and out_ready=0: data_out overwritten, out_valid stays 1, overrun set.
REQ-021 New result in same cycle as acceptance: new result loaded, out_valid stays 1, overrun unchanged.
REQ-022 overrun SHALL remain set until reset.
REQ-023 bit_valid=0 cycles SHALL freeze integrators, counter and FSM; output handshake continues.

Reset
REQ-024 With reset=0 at a clk edge: integrators, combs, counter cleared; FSM=WARM0; data_out=0; out_valid=0; overrun=0.
REQ-025 Reset asserted mid-window or with out_valid=1 SHALL discard all partial and pending results.

Configuration
REQ-026 Macro DSM_DEC_SAT_EN defined: y >= 2^OUT_W SHALL clamp data_out to all-ones (0xFFFF at defaults).
REQ-027 Macro DSM_DEC_SAT_EN undefined: data_out SHALL be y modulo 2^OUT_W (all-ones input yields 0x0000 at defaults).

Structure
REQ-028 Package dsm_dec_pkg SHALL hold the FSM state enum, default DECIM_LOG2/OUT_W constants and derived accumulator width.
REQ-029 Comb stage (difference-with-delay, enabled at dump) SHALL be sub-module dsm_dec_comb, instantiated twice.

Verification
REQ-030 Reset, bit_valid=1 every cycle, bit_in=0 -> first out_valid after 3*256 samples +1 cycle, data_out=0x0000.
REQ-031 bit_in=1 constant -> data_out=0xFFFF with DSM_DEC_SAT_EN, 0x0000 without.
REQ-032 bit_in alternating 1,0 -> every result data_out=0x8000, one result per 256 samples.
REQ-033 out_ready=0 across two dumps -> overrun=1, data_out equals second result; out_ready=1 with coincident dump -> overrun stays 0.
REQ-034 Driven by dsm_3 with alpha=0x4000 -> steady-state data_out within 0x4000 +/- 0x0100.
REQ-035 Reset pulse at sample 100 of a RUN window -> all outputs 0 next cycle; next result only after three full windows.
